memoria_datos: RTL and testbench

Byte-addressable 64 KiB data memory for the single-cycle microprocessor datapath, organised as 16384 words of 32 bits. It serves load-word, load-byte, store-word and store-byte accesses from the ALU-computed address. Reads are combinational and writes are synchronous. `dirGPIO` from the address decoder gates the block so that GPIO-mapped accesses leave the RAM untouched.

---
 rtl/memoria_datos_if.sv | 30 +++
 rtl/memoria_datos.sv | 74 +++++++
 tb/tb_memoria_datos.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/memoria_datos_if.sv
// Bus bundle for the data memory: address, write data, access controls and read data.
interface memoria_datos_if;
  logic [31:0] A;
  logic [31:0] WD;
  logic        MW;
  logic        SB;
  logic        loadByte;
  logic        dirGPIO;
  logic [31:0] RD;

  modport master (
    output A,
    output WD,
    output MW,
    output SB,
    output loadByte,
    output dirGPIO,
    input  RD
  );

  modport slave (
    input  A,
    input  WD,
    input  MW,
    input  SB,
    input  loadByte,
    input  dirGPIO,
    output RD
  );
endinterface

// File: rtl/memoria_datos.sv
// Byte-addressable data memory: combinational word/byte reads, synchronous word/byte writes,
// gated by the GPIO address decode and an active-low reset.
module memoria_datos #(
  parameter int unsigned ADDR_BITS = 16,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  memoria_datos_if.slave  bus
);

  localparam int unsigned Depth = 1 << (ADDR_BITS - 2);

  logic [31:0]          mem_q [Depth] = '{default: (INIT_ZERO ? 32'h0 : 32'hx)};
  logic [31:0]          mem_d;
  logic [ADDR_BITS-3:0] word_idx;
  logic [1:0]           lane;
  logic [31:0]          rd_word;
  logic [7:0]           rd_byte;
  logic [31:0]          rd;
  logic                 we;
  logic                 unused_a;

  assign word_idx = bus.A[ADDR_BITS-1:2];
  assign lane     = bus.A[1:0];
  assign unused_a = ^bus.A[31:ADDR_BITS];
  assign rd_word  = mem_q[word_idx];

  // Reset is sampled at the edge, so a reset that falls mid-cycle drops the pending write.
  assign we = bus.MW & bus.dirGPIO & reset;

  always_comb begin
    rd_byte = rd_word[7:0];
    unique case (lane)
      2'd0: rd_byte = rd_word[7:0];
      2'd1: rd_byte = rd_word[15:8];
      2'd2: rd_byte = rd_word[23:16];
      2'd3: rd_byte = rd_word[31:24];
      default: rd_byte = rd_word[7:0];
    endcase
  end

  always_comb begin
    mem_d = rd_word;
    if (bus.SB) begin
      unique case (lane)
        2'd0: mem_d[7:0]   = bus.WD[7:0];
        2'd1: mem_d[15:8]  = bus.WD[7:0];
        2'd2: mem_d[23:16] = bus.WD[7:0];
        2'd3: mem_d[31:24] = bus.WD[7:0];
        default: mem_d = rd_word;
      endcase
    end else begin
      mem_d = bus.WD;
    end
  end

  // No reset on the array so it stays inferable as block RAM.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[word_idx] <= mem_d;
    end
  end

  always_comb begin
    rd = 32'h0;
    if (reset && bus.dirGPIO) begin
      rd = bus.loadByte ? {24'h0, rd_byte} : rd_word;
    end
  end

  assign bus.RD = rd;

endmodule

// File: tb/tb_memoria_datos.sv
// Self-checking bench for memoria_datos: directed scenarios plus randomized traffic
// compared against a word-array reference model.
module tb_memoria_datos;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  bit [31:0] model_mem [16384];

  memoria_datos_if bus ();

  memoria_datos #(
    .ADDR_BITS (16),
    .INIT_ZERO (1'b1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int unsigned widx(input bit [31:0] a);
    return (a / 4) % 16384;
  endfunction

  function automatic bit [31:0] m_read(input bit [31:0] a, input bit lb, input bit gp,
                                       input bit rst_n);
    bit [31:0] w;
    if (!rst_n || !gp) return 32'h0;
    w = model_mem[widx(a)];
    if (lb) return (w >> (8 * (a % 4))) & 32'hFF;
    return w;
  endfunction

  function automatic void m_write(input bit [31:0] a, input bit [31:0] wd, input bit sb);
    int unsigned sh;
    if (!sb) begin
      model_mem[widx(a)] = wd;
    end else begin
      sh = 8 * (a % 4);
      model_mem[widx(a)] = (model_mem[widx(a)] & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
    end
  endfunction

  task automatic drive(input bit [31:0] a, input bit [31:0] wd, input bit mw, input bit sb,
                       input bit lb, input bit gp);
    bus.A        = a;
    bus.WD       = wd;
    bus.MW       = mw;
    bus.SB       = sb;
    bus.loadByte = lb;
    bus.dirGPIO  = gp;
  endtask

  // Store through the DUT at the next edge and mirror it in the model.
  task automatic store(input bit [31:0] a, input bit [31:0] wd, input bit sb);
    @(negedge clock);
    drive(a, wd, 1'b1, sb, 1'b0, 1'b1);
    @(posedge clock);
    m_write(a, wd, sb);
    #1;
    bus.MW = 1'b0;
  endtask

  task automatic test_reset;
    drive(32'd24, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    checks++;
    if (bus.RD !== 32'h0) begin
      $display("FAIL reset_rd: got %h want %h", bus.RD, 32'h0);
      errors++;
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.RD !== 32'h0) begin
      $display("FAIL init_zero: got %h want %h", bus.RD, 32'h0);
      errors++;
    end
  endtask

  task automatic test_word_read;
    store(32'd24, 32'hDEADBEEF, 1'b0);
    @(negedge clock);
    drive(32'd24, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.RD !== 32'hDEADBEEF) begin
      $display("FAIL word_read: got %h want %h", bus.RD, 32'hDEADBEEF);
      errors++;
    end
  endtask

  task automatic test_byte_store;
    store(32'd72, 32'h11223344, 1'b0);
    store(32'd72, 32'd1114, 1'b1);
    drive(32'd72, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.RD !== 32'h1122335A) begin
      $display("FAIL byte_store_lane0: got %h want %h", bus.RD, 32'h1122335A);
      errors++;
    end
    store(32'd73, 32'hFF, 1'b1);
    drive(32'd72, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.RD !== 32'h1122FF5A) begin
      $display("FAIL byte_store_lane1: got %h want %h", bus.RD, 32'h1122FF5A);
      errors++;
    end
  endtask

  task automatic test_unaligned_and_byte_load;
    bit [31:0] exp_b [3];
    bit [31:0] adr_b [3];
    store(32'h0000ABCD, 32'h013875AC, 1'b0);
    drive(32'h0000ABCC, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.RD !== 32'h013875AC) begin
      $display("FAIL unaligned_word: got %h want %h", bus.RD, 32'h013875AC);
      errors++;
    end
    adr_b = '{32'h0000ABCC, 32'h0000ABCE, 32'h0000ABCF};
    exp_b = '{32'h000000AC, 32'h00000038, 32'h00000001};
    for (int i = 0; i < 3; i++) begin
      drive(adr_b[i], 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      #1;
      checks++;
      if (bus.RD !== exp_b[i]) begin
        $display("FAIL byte_load[%0d]: got %h want %h", i, bus.RD, exp_b[i]);
        errors++;
      end
    end
  endtask

  task automatic test_gpio;
    @(negedge clock);
    drive(32'd72, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.RD !== 32'h0) begin
      $display("FAIL gpio_rd: got %h want %h", bus.RD, 32'h0);
      errors++;
    end
    @(posedge clock);
    #1;
    @(negedge clock);
    drive(32'd72, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.RD !== 32'h1122FF5A) begin
      $display("FAIL gpio_no_write: got %h want %h", bus.RD, 32'h1122FF5A);
      errors++;
    end
  endtask

  task automatic test_reset_write;
    bit [31:0] old2;
    old2 = model_mem[2];
    @(negedge clock);
    reset = 1'b0;
    drive(32'd8, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.RD !== 32'h0) begin
      $display("FAIL reset_write_rd: got %h want %h", bus.RD, 32'h0);
      errors++;
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.RD !== old2) begin
      $display("FAIL reset_write_dropped: got %h want %h", bus.RD, old2);
      errors++;
    end
    @(posedge clock);
    m_write(32'd8, 32'hCAFEF00D, 1'b0);
    #1;
    checks++;
    if (bus.RD !== 32'hCAFEF00D) begin
      $display("FAIL reset_release_write: got %h want %h", bus.RD, 32'hCAFEF00D);
      errors++;
    end
    @(negedge clock);
    drive(32'd72, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.RD !== 32'h1122FF5A) begin
      $display("FAIL reset_keeps_contents: got %h want %h", bus.RD, 32'h1122FF5A);
      errors++;
    end
  endtask

  task automatic test_back_to_back;
    for (int l = 0; l < 4; l++) begin
      store(32'h00000400 + l, 32'hA0 + l, 1'b1);
    end
    drive(32'h00000402, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.RD !== 32'hA3A2A1A0) begin
      $display("FAIL back_to_back: got %h want %h", bus.RD, 32'hA3A2A1A0);
      errors++;
    end
  endtask

  task automatic test_random;
    bit [31:0] a;
    bit [31:0] wd;
    bit [31:0] exp;
    bit        mw;
    bit        sb;
    bit        lb;
    bit        gp;
    for (int n = 0; n < 400; n++) begin
      // Small word window so reads hit earlier writes; upper bits must be ignored.
      a  = ($urandom() & 32'hFFFF0000) | ($urandom_range(0, 31) * 4) | $urandom_range(0, 3);
      wd = $urandom();
      mw = ($urandom_range(0, 1) == 1);
      sb = ($urandom_range(0, 1) == 1);
      lb = ($urandom_range(0, 1) == 1);
      gp = ($urandom_range(0, 4) != 0);
      @(negedge clock);
      drive(a, wd, mw, sb, lb, gp);
      #1;
      exp = m_read(a, lb, gp, 1'b1);
      checks++;
      if (bus.RD !== exp) begin
        $display("FAIL random_pre[%0d] a=%h: got %h want %h", n, a, bus.RD, exp);
        errors++;
      end
      @(posedge clock);
      if (mw && gp) m_write(a, wd, sb);
      #1;
      exp = m_read(a, lb, gp, 1'b1);
      checks++;
      if (bus.RD !== exp) begin
        $display("FAIL random_post[%0d] a=%h: got %h want %h", n, a, bus.RD, exp);
        errors++;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    test_reset();
    test_word_read();
    test_byte_store();
    test_unaligned_and_byte_load();
    test_gpio();
    test_reset_write();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
